// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the key schedule and, later, the cipher
// datapath: round/word counts, the round-constant table, the forward S-box
// table and the key-schedule FSM state type.
// -----------------------------------------------------------------------------
package aes_pkg;

  // Rounds for AES-128 and 32-bit words per round key.
  localparam int NR  = 10;
  localparam int NK  = 4;
  localparam int RKW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  // Round constant for rounds 1..10 (the byte that lands in bits [31:24]).
  // Round 0 and anything past 10 never use it and return zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// Combinational SubWord: four independent forward S-box lookups, one per byte.
// Also intended for reuse by the SubBytes stage.
//
// Ports:
//   word_i  32-bit input word
//   word_o  32-bit word with every byte substituted through the S-box
// -----------------------------------------------------------------------------
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_o[8*gi +: 8] = SBOX[word_i[8*gi +: 8]];
  end

endmodule

// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand
// AES-128 key schedule. A loaded cipher key is expanded one round key per
// cycle into an 11-entry round-key store; once complete, round keys are served
// with one cycle of latency, indexed forward (encode) or reversed (decode).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   key_valid/key_ready load handshake; key0 is the most significant word
//   key0..key3          128-bit cipher key
//   keys_ready          the store holds a complete schedule
//   encode              1 = forward index, 0 = reversed index (with rk_req)
//   rk_req, rk_round    read request for step 0..10
//   rk_valid, rk_err    one-cycle response pulse; rk_err for rk_round > 10
//   rk0..rk3            round-key words (zero on an error response)
// -----------------------------------------------------------------------------
module aes_key_expand #(
  parameter int NR  = 10,
  parameter int RKW = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [RKW-1:0] key0,
  input  logic [RKW-1:0] key1,
  input  logic [RKW-1:0] key2,
  input  logic [RKW-1:0] key3,
  output logic           keys_ready,
  input  logic           encode,
  input  logic           rk_req,
  input  logic [3:0]     rk_round,
  output logic           rk_valid,
  output logic           rk_err,
  output logic [RKW-1:0] rk0,
  output logic [RKW-1:0] rk1,
  output logic [RKW-1:0] rk2,
  output logic [RKW-1:0] rk3
);

  import aes_pkg::*;

  localparam int KW = NK * RKW;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ks_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  // Previous round key, so the next one is derived without a store read.
  logic [KW-1:0] work_q, work_d;

  logic [KW-1:0] store_q [0:NR];
  logic          store_we;
  logic [3:0]    store_waddr;
  logic [KW-1:0] store_wdata;

  logic          rk_valid_q, rk_valid_d;
  logic          rk_err_q, rk_err_d;
  logic [KW-1:0] rk_q;

  logic          key_accept;
  logic          rd_fire;
  logic          rd_err;
  logic [3:0]    rd_idx;

  // ---------------------------------------------------------------------------
  // Next round key from the working register
  // ---------------------------------------------------------------------------
  logic [RKW-1:0] last_word;
  logic [RKW-1:0] rot_word;
  logic [RKW-1:0] sub_word;
  logic [RKW-1:0] temp_word;
  logic [KW-1:0]  next_key;

  assign last_word = work_q[RKW-1:0];
  // RotWord is a one-byte left rotation, done purely by wiring.
  assign rot_word  = {last_word[RKW-9:0], last_word[RKW-1 -: 8]};

  aes_subword u_subword (
    .word_i (rot_word),
    .word_o (sub_word)
  );

  assign temp_word = sub_word ^ {rcon(cnt_q), {(RKW-8){1'b0}}};

  // Each new word is the word four back XOR the word just produced; word 0
  // of the round uses temp in place of the word just produced.
  always_comb begin
    logic [RKW-1:0] carry;
    next_key = '0;
    carry    = temp_word;
    for (int i = 0; i < NK; i++) begin
      carry = work_q[KW-1-RKW*i -: RKW] ^ carry;
      next_key[KW-1-RKW*i -: RKW] = carry;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  assign key_ready  = (state_q != EXPAND);
  assign keys_ready = (state_q == READY);
  assign key_accept = key_valid && key_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    store_we    = 1'b0;
    store_waddr = '0;
    store_wdata = '0;

    case (state_q)
      IDLE, READY: begin
        if (key_accept) begin
          state_d     = EXPAND;
          cnt_d       = 4'd1;
          work_d      = {key0, key1, key2, key3};
          store_we    = 1'b1;
          store_waddr = 4'd0;
          store_wdata = {key0, key1, key2, key3};
        end
      end
      EXPAND: begin
        store_we    = 1'b1;
        store_waddr = cnt_q;
        store_wdata = next_key;
        work_d      = next_key;
        if (cnt_q == 4'(NR)) begin
          state_d = READY;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  assign rd_fire    = rk_req && (state_q == READY);
  assign rd_err     = (rk_round > 4'(NR));
  assign rd_idx     = encode ? rk_round : 4'(NR) - rk_round;
  assign rk_valid_d = rd_fire;
  assign rk_err_d   = rd_fire && rd_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_valid_q <= 1'b0;
      rk_err_q   <= 1'b0;
    end else begin
      rk_valid_q <= rk_valid_d;
      rk_err_q   <= rk_err_d;
    end
  end

  // Round-key store. The registered read samples the old contents, so a read
  // on the same edge as a key load still returns the previous schedule.
  always_ff @(posedge clk) begin
    if (store_we) begin
      store_q[store_waddr] <= store_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_q <= '0;
    end else if (rd_fire) begin
      rk_q <= rd_err ? '0 : store_q[rd_idx];
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_err   = rk_err_q;
  assign rk0      = rk_q[KW-1 -: RKW];
  assign rk1      = rk_q[KW-1-RKW -: RKW];
  assign rk2      = rk_q[KW-1-2*RKW -: RKW];
  assign rk3      = rk_q[RKW-1:0];

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand
// Self-checking bench for aes_key_expand. The reference schedule is derived
// from GF(2^8) arithmetic (S-box from inverse + affine map, Rcon by doubling)
// and the word-recurrence form of the key expansion.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key0, key1, key2, key3;
  logic        keys_ready;
  logic        encode;
  logic        rk_req;
  logic [3:0]  rk_round;
  logic        rk_valid;
  logic        rk_err;
  logic [31:0] rk0, rk1, rk2, rk3;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] exp_rk [11];

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key0       (key0),
    .key1       (key1),
    .key2       (key2),
    .key3       (key3),
    .keys_ready (keys_ready),
    .encode     (encode),
    .rk_req     (rk_req),
    .rk_round   (rk_round),
    .rk_valid   (rk_valid),
    .rk_err     (rk_err),
    .rk0        (rk0),
    .rk1        (rk1),
    .rk2        (rk2),
    .rk3        (rk3)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] r;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    rcon_m[0] = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      rcon_m[i] = r;
      r = xtime(r);
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_read(input bit enc, input int rnd);
    if (rnd > 10) return '0;
    return enc ? exp_rk[rnd] : exp_rk[10 - rnd];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    {key0, key1, key2, key3} = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic read_rk(input bit enc, input logic [3:0] rnd,
                         output logic [127:0] data, output logic v, output logic e);
    @(negedge clk);
    rk_req   = 1'b1;
    encode   = enc;
    rk_round = rnd;
    @(negedge clk);
    rk_req = 1'b0;
    v      = rk_valid;
    e      = rk_err;
    data   = {rk0, rk1, rk2, rk3};
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; rk_req = 1'b0; encode = 1'b1; rk_round = '0;
    {key0, key1, key2, key3} = '0;
    idle_cycles(3);
    checks++;
    if ({key_ready, keys_ready, rk_valid, rk_err} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got kr=%b ksr=%b v=%b e=%b, expected 1 0 0 0", key_ready, keys_ready, rk_valid, rk_err);
    end
    checks++;
    if ({rk0, rk1, rk2, rk3} !== 128'h0) begin
      errors++;
      $display("FAIL reset_rk: got %h expected 0", {rk0, rk1, rk2, rk3});
    end
    rst_n = 1'b1;
    idle_cycles(1);
    $display("test_reset done");
  endtask

  task automatic test_fips_expand();
    load_key(FIPS_KEY);
    checks++;
    if (key_ready !== 1'b0 || keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_flags_T: got kr=%b ksr=%b expected 0 0", key_ready, keys_ready);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (keys_ready !== (i == 10) || key_ready !== (i == 10)) begin
        errors++;
        $display("FAIL expand_timing T+%0d: got ksr=%b kr=%b expected %b", i, keys_ready, key_ready, i == 10);
      end
    end
    model_expand(FIPS_KEY);
    $display("test_fips_expand done");
  endtask

  task automatic test_fips_reads();
    logic [127:0] d; logic v, e;
    read_rk(1'b1, 4'd1, d, v, e);
    checks++;
    if (d !== FIPS_R1 || v !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL enc_r1: got %h v=%b e=%b expected %h v=1 e=0", d, v, e, FIPS_R1);
    end
    read_rk(1'b1, 4'd10, d, v, e);
    checks++;
    if (d !== FIPS_R10 || v !== 1'b1 || e !== 1'b0) begin
      errors++; $display("FAIL enc_r10: got %h v=%b e=%b expected %h", d, v, e, FIPS_R10);
    end
    read_rk(1'b0, 4'd0, d, v, e);
    checks++;
    if (d !== FIPS_R10 || v !== 1'b1) begin
      errors++; $display("FAIL dec_r0: got %h v=%b expected %h", d, v, FIPS_R10);
    end
    read_rk(1'b0, 4'd10, d, v, e);
    checks++;
    if (d !== FIPS_KEY || v !== 1'b1) begin
      errors++; $display("FAIL dec_r10: got %h v=%b expected %h", d, v, FIPS_KEY);
    end
    for (int r = 11; r <= 15; r += 4) begin
      read_rk(1'b1, 4'(r), d, v, e);
      checks++;
      if (d !== 128'h0 || v !== 1'b1 || e !== 1'b1) begin
        errors++; $display("FAIL out_of_range r=%0d: got %h v=%b e=%b expected 0 v=1 e=1", r, d, v, e);
      end
    end
    // Error flag must be a single-cycle pulse.
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || rk_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got v=%b e=%b expected 0 0", rk_valid, rk_err);
    end
    // Full schedule, both directions, against the model.
    for (int r = 0; r <= 10; r++) begin
      for (int en = 0; en < 2; en++) begin
        read_rk(en[0], 4'(r), d, v, e);
        checks++;
        if (d !== model_read(en[0], r) || v !== 1'b1 || e !== 1'b0) begin
          errors++; $display("FAIL model_read enc=%0d r=%0d: got %h v=%b expected %h", en, r, d, v, model_read(en[0], r));
        end
      end
    end
    $display("test_fips_reads done");
  endtask

  task automatic test_back_to_back();
    int rnd [8]; bit enc [8];
    logic [127:0] last;
    for (int k = 0; k < 8; k++) begin
      rnd[k] = $urandom_range(0, 12);
      enc[k] = 1'($urandom);
    end
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        rk_req = 1'b1; encode = enc[k]; rk_round = 4'(rnd[k]);
      end else begin
        rk_req = 1'b0;
      end
      if (k > 0) begin
        checks++;
        if ({rk0, rk1, rk2, rk3} !== model_read(enc[k-1], rnd[k-1]) || rk_valid !== 1'b1 || rk_err !== (rnd[k-1] > 10)) begin
          errors++;
          $display("FAIL b2b k=%0d enc=%0d r=%0d: got %h v=%b e=%b expected %h", k-1, enc[k-1], rnd[k-1], {rk0, rk1, rk2, rk3}, rk_valid, rk_err, model_read(enc[k-1], rnd[k-1]));
        end
      end
      @(negedge clk);
    end
    last = model_read(enc[7], rnd[7]);
    checks++;
    if (rk_valid !== 1'b0 || {rk0, rk1, rk2, rk3} !== last) begin
      errors++; $display("FAIL hold: got %h v=%b expected %h v=0", {rk0, rk1, rk2, rk3}, rk_valid, last);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_req_during_expand();
    logic [127:0] d; logic v, e;
    load_key(FIPS_KEY);
    for (int i = 1; i <= 10; i++) begin
      rk_req = 1'b1; encode = 1'b1; rk_round = 4'd3;
      key_valid = 1'b1; {key0, key1, key2, key3} = ~FIPS_KEY;
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b0 || keys_ready !== (i == 10)) begin
        errors++; $display("FAIL busy_req T+%0d: got v=%b ksr=%b expected v=0 ksr=%b", i, rk_valid, keys_ready, i == 10);
      end
    end
    rk_req = 1'b0; key_valid = 1'b0;
    read_rk(1'b1, 4'd10, d, v, e);
    checks++;
    if (d !== FIPS_R10 || v !== 1'b1) begin
      errors++; $display("FAIL key_ignored: got %h expected %h", d, FIPS_R10);
    end
    $display("test_req_during_expand done");
  endtask

  task automatic test_reset_mid_expand();
    logic [127:0] d; logic v, e;
    load_key({$urandom, $urandom, $urandom, $urandom});
    idle_cycles(4);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (keys_ready !== 1'b0 || key_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got ksr=%b kr=%b expected 0 1", keys_ready, key_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (keys_ready !== 1'b0) begin
        errors++; $display("FAIL partial_ready cyc=%0d: got ksr=%b expected 0", i, keys_ready);
      end
    end
    read_rk(1'b1, 4'd0, d, v, e);
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL idle_req: got v=%b expected 0", v);
    end
    $display("test_reset_mid_expand done");
  endtask

  task automatic test_zero_key();
    logic [127:0] d; logic v, e;
    load_key(128'h0);
    idle_cycles(10);
    model_expand(128'h0);
    read_rk(1'b1, 4'd10, d, v, e);
    checks++;
    if (d !== ZERO_R10 || v !== 1'b1) begin
      errors++; $display("FAIL zero_r10: got %h v=%b expected %h", d, v, ZERO_R10);
    end
    $display("test_zero_key done");
  endtask

  task automatic test_random_keys();
    logic [127:0] k, d; logic v, e; int r; bit en;
    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      idle_cycles(10);
      model_expand(k);
      for (int j = 0; j < 6; j++) begin
        r  = $urandom_range(0, 10);
        en = 1'($urandom);
        read_rk(en, 4'(r), d, v, e);
        checks++;
        if (d !== model_read(en, r) || v !== 1'b1 || e !== 1'b0) begin
          errors++; $display("FAIL rand key=%h enc=%0d r=%0d: got %h expected %h", k, en, r, d, model_read(en, r));
        end
      end
      $display("random key %h checked", k);
    end
  endtask

  task automatic test_simul_load_read();
    logic [127:0] k_new, old5, d; logic v, e;
    k_new = {$urandom, $urandom, $urandom, $urandom};
    old5  = model_read(1'b1, 5);
    @(negedge clk);
    key_valid = 1'b1; {key0, key1, key2, key3} = k_new;
    rk_req = 1'b1; encode = 1'b1; rk_round = 4'd5;
    @(negedge clk);
    key_valid = 1'b0; rk_req = 1'b0;
    checks++;
    if ({rk0, rk1, rk2, rk3} !== old5 || rk_valid !== 1'b1 || keys_ready !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL simul_old: got %h v=%b ksr=%b kr=%b expected %h v=1 ksr=0 kr=0", {rk0, rk1, rk2, rk3}, rk_valid, keys_ready, key_ready, old5);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (keys_ready !== (i == 10)) begin
        errors++; $display("FAIL simul_expand T+%0d: got ksr=%b expected %b", i, keys_ready, i == 10);
      end
    end
    model_expand(k_new);
    read_rk(1'b0, 4'd0, d, v, e);
    checks++;
    if (d !== exp_rk[10] || v !== 1'b1) begin
      errors++; $display("FAIL simul_new: got %h expected %h", d, exp_rk[10]);
    end
    read_rk(1'b1, 4'd5, d, v, e);
    checks++;
    if (d !== exp_rk[5] || v !== 1'b1) begin
      errors++; $display("FAIL simul_new5: got %h expected %h", d, exp_rk[5]);
    end
    $display("test_simul_load_read done");
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips_expand();
    test_fips_reads();
    test_back_to_back();
    test_req_during_expand();
    test_reset_mid_expand();
    test_zero_key();
    test_random_keys();
    test_simul_load_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
